// File: rtl/rbcp_reg_bank_pkg.sv
// Shared constants and helpers for the RBCP AXI4-Lite register bank.
package rbcp_reg_bank_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int DEF_N_CTRL = 8;
    localparam int DEF_N_STAT = 4;
    localparam int DEF_ADDR_W = 8;

    // Replace only the bytes of old_word whose strobe bit is set.
    function automatic logic [31:0] strb_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  strb
    );
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = strb[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/rbcp_reg_bank_wcnt.sv
// Committed-write counter; cleared by rst or clr, wraps naturally at 2^32.
module rbcp_reg_bank_wcnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        inc,
    input  logic        clr,
    output logic [31:0] count
);

    logic [31:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc) begin
            count_reg <= count_reg + 32'd1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/rbcp_reg_bank.sv
// AXI4-Lite register bank: N_CTRL r/w control words, N_STAT read-only status words.
// Define RBCP_REG_BANK_WCNT_EN to add a committed-write counter at word N_CTRL+N_STAT.
module rbcp_reg_bank
    import rbcp_reg_bank_pkg::*;
#(
    parameter int N_CTRL = DEF_N_CTRL,
    parameter int N_STAT = DEF_N_STAT,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           s_axi_awaddr,
    input  logic [2:0]            s_axi_awprot,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [31:0]           s_axi_araddr,
    input  logic [2:0]            s_axi_arprot,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [32*N_CTRL-1:0]  ctrl_out,
    output logic [N_CTRL-1:0]     ctrl_wr,
    input  logic [32*N_STAT-1:0]  status_in
);

    localparam int IDX_W = ADDR_W - 2;

    logic              aw_held_reg;
    logic              w_held_reg;
    logic [IDX_W-1:0]  aw_idx_reg;
    logic [31:0]       w_data_reg;
    logic [3:0]        w_strb_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic              rvalid_reg;
    logic [1:0]        rresp_reg;
    logic [31:0]       rdata_reg;

    logic              commit;
    logic [31:0]       wr_word;
    logic [31:0]       rd_word;
    logic              wr_is_ctrl;
    logic              wr_ok;
    logic [31:0]       rd_data_next;
    logic [1:0]        rd_resp_next;

    // Address bits outside the decoded window alias; protection is not checked.
    logic unused_bits;
    assign unused_bits = ^{s_axi_awprot, s_axi_arprot,
                           s_axi_awaddr[31:ADDR_W], s_axi_awaddr[1:0],
                           s_axi_araddr[31:ADDR_W], s_axi_araddr[1:0]};

    assign s_axi_awready = ~aw_held_reg & ~bvalid_reg;
    assign s_axi_wready  = ~w_held_reg & ~bvalid_reg;
    assign s_axi_bvalid  = bvalid_reg;
    assign s_axi_bresp   = bresp_reg;
    assign s_axi_arready = ~rvalid_reg;
    assign s_axi_rvalid  = rvalid_reg;
    assign s_axi_rresp   = rresp_reg;
    assign s_axi_rdata   = rdata_reg;

    assign commit     = aw_held_reg & w_held_reg;
    assign wr_word    = 32'(aw_idx_reg);
    assign rd_word    = 32'(s_axi_araddr[ADDR_W-1:2]);
    assign wr_is_ctrl = (wr_word < N_CTRL);

`ifdef RBCP_REG_BANK_WCNT_EN
    localparam int WCNT_IDX = N_CTRL + N_STAT;

    logic        wr_is_cnt;
    logic [31:0] wcnt_count;

    assign wr_is_cnt = (wr_word == WCNT_IDX);
    assign wr_ok     = wr_is_ctrl | wr_is_cnt;

    // Only control-word commits count; the clearing write itself does not.
    rbcp_reg_bank_wcnt u_wcnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit & wr_is_ctrl),
        .clr   (commit & wr_is_cnt),
        .count (wcnt_count)
    );
`else
    assign wr_ok = wr_is_ctrl;
`endif

    // Write channel: AW and W park independently; the commit happens one edge after both are parked.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            aw_idx_reg  <= '0;
            w_data_reg  <= '0;
            w_strb_reg  <= '0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
        end else begin
            if (s_axi_awvalid && s_axi_awready) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= s_axi_awaddr[ADDR_W-1:2];
            end
            if (s_axi_wvalid && s_axi_wready) begin
                w_held_reg <= 1'b1;
                w_data_reg <= s_axi_wdata;
                w_strb_reg <= s_axi_wstrb;
            end
            if (commit) begin
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
                bvalid_reg  <= 1'b1;
                bresp_reg   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (bvalid_reg && s_axi_bready) begin
                bvalid_reg <= 1'b0;
            end
        end
    end

    for (genvar gi = 0; gi < N_CTRL; gi++) begin : g_ctrl
        logic [31:0] word_reg;
        logic        wr_pulse_reg;
        logic        hit;

        assign hit = commit && (wr_word == gi);

        always_ff @(posedge clk) begin
            if (rst) begin
                word_reg     <= '0;
                wr_pulse_reg <= 1'b0;
            end else begin
                wr_pulse_reg <= hit;
                if (hit) begin
                    word_reg <= strb_merge(word_reg, w_data_reg, w_strb_reg);
                end
            end
        end

        assign ctrl_out[32*gi +: 32] = word_reg;
        assign ctrl_wr[gi]           = wr_pulse_reg;
    end

    always_comb begin
        rd_data_next = '0;
        rd_resp_next = RESP_SLVERR;
        for (int k = 0; k < N_CTRL; k++) begin
            if (rd_word == k) begin
                rd_data_next = ctrl_out[32*k +: 32];
                rd_resp_next = RESP_OKAY;
            end
        end
        for (int k = 0; k < N_STAT; k++) begin
            if (rd_word == N_CTRL + k) begin
                rd_data_next = status_in[32*k +: 32];
                rd_resp_next = RESP_OKAY;
            end
        end
`ifdef RBCP_REG_BANK_WCNT_EN
        if (rd_word == WCNT_IDX) begin
            rd_data_next = wcnt_count;
            rd_resp_next = RESP_OKAY;
        end
`endif
    end

    // Read data is captured from current register state, so a same-edge write is not yet visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
            rresp_reg  <= RESP_OKAY;
        end else if (s_axi_arvalid && s_axi_arready) begin
            rvalid_reg <= 1'b1;
            rdata_reg  <= rd_data_next;
            rresp_reg  <= rd_resp_next;
        end else if (rvalid_reg && s_axi_rready) begin
            rvalid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rbcp_reg_bank.sv
// Directed self-checking bench for rbcp_reg_bank (default parameters).
module tb_rbcp_reg_bank;
    import rbcp_reg_bank_pkg::*;

    localparam int N_CTRL = 8;
    localparam int N_STAT = 4;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0]          s_axi_awaddr = '0;
    logic [2:0]           s_axi_awprot = '0;
    logic                 s_axi_awvalid = 1'b0;
    logic                 s_axi_awready;
    logic [31:0]          s_axi_wdata = '0;
    logic [3:0]           s_axi_wstrb = '0;
    logic                 s_axi_wvalid = 1'b0;
    logic                 s_axi_wready;
    logic [1:0]           s_axi_bresp;
    logic                 s_axi_bvalid;
    logic                 s_axi_bready = 1'b0;
    logic [31:0]          s_axi_araddr = '0;
    logic [2:0]           s_axi_arprot = '0;
    logic                 s_axi_arvalid = 1'b0;
    logic                 s_axi_arready;
    logic [31:0]          s_axi_rdata;
    logic [1:0]           s_axi_rresp;
    logic                 s_axi_rvalid;
    logic                 s_axi_rready = 1'b0;
    logic [32*N_CTRL-1:0] ctrl_out;
    logic [N_CTRL-1:0]    ctrl_wr;
    logic [32*N_STAT-1:0] status_in = {32'h0000C0DE, 32'h33333333, 32'h22222222, 32'hDEADBEEF};

    rbcp_reg_bank #(.N_CTRL(N_CTRL), .N_STAT(N_STAT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .ctrl_out(ctrl_out), .ctrl_wr(ctrl_wr), .status_in(status_in)
    );

    int checks = 0;
    int failures = 0;
    int pulses [N_CTRL];

    always @(negedge clk) begin
        for (int k = 0; k < N_CTRL; k++) begin
            if (ctrl_wr[k] === 1'b1) pulses[k]++;
        end
    end

    function automatic logic [31:0] word(input int k);
        return ctrl_out[32*k +: 32];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_b(input int delay, output logic [1:0] resp, output int lat);
        lat = 0;
        while (s_axi_bvalid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bvalid_seen", {31'd0, s_axi_bvalid}, 32'd1);
        resp = s_axi_bresp;
        repeat (delay) begin
            @(negedge clk);
            check("b_hold_bv_awr_wr", {29'd0, s_axi_bvalid, s_axi_awready, s_axi_wready}, 32'd4);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int delay, output logic [1:0] resp, output int lat);
        bit aw_done, w_done, aw_rdy, w_rdy;
        int t;
        aw_done = 0; w_done = 0; t = 0;
        @(negedge clk);
        s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
        while (!(aw_done && w_done) && t < 20) begin
            aw_rdy = s_axi_awready; w_rdy = s_axi_wready;
            @(posedge clk);
            if (s_axi_awvalid && aw_rdy) aw_done = 1;
            if (s_axi_wvalid && w_rdy) w_done = 1;
            @(negedge clk);
            if (aw_done) s_axi_awvalid = 1'b0;
            if (w_done) s_axi_wvalid = 1'b0;
            t++;
        end
        check("wr_handshake", {30'd0, aw_done, w_done}, 32'd3);
        wait_b(delay, resp, lat);
        $display("WRITE addr=%h data=%h strb=%h bresp=%0d lat=%0d", addr, data, strb, resp, lat);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int delay,
                            output logic [31:0] data, output logic [1:0] resp, output int lat);
        bit ar_done, ar_rdy;
        int t;
        ar_done = 0; t = 0;
        @(negedge clk);
        s_axi_araddr = addr; s_axi_arvalid = 1'b1;
        while (!ar_done && t < 20) begin
            ar_rdy = s_axi_arready;
            @(posedge clk);
            if (ar_rdy) ar_done = 1;
            @(negedge clk);
            if (ar_done) s_axi_arvalid = 1'b0;
            t++;
        end
        check("rd_handshake", {31'd0, ar_done}, 32'd1);
        lat = 0;
        while (s_axi_rvalid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("rvalid_seen", {31'd0, s_axi_rvalid}, 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        repeat (delay) begin
            @(negedge clk);
            check("r_hold_data", s_axi_rdata, data);
            check("r_hold_rv_arr", {30'd0, s_axi_rvalid, s_axi_arready}, 32'd2);
        end
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("rvalid_clear", {31'd0, s_axi_rvalid}, 32'd0);
        $display("READ  addr=%h rdata=%h rresp=%0d lat=%0d", addr, data, resp, lat);
    endtask

    logic [1:0]  resp;
    logic [31:0] rdata;
    int          lat;

    initial begin
        for (int k = 0; k < N_CTRL; k++) pulses[k] = 0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", {29'd0, s_axi_awready, s_axi_wready, s_axi_arready}, 32'd7);
        check("rst_valid", {30'd0, s_axi_bvalid, s_axi_rvalid}, 32'd0);
        check("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
        check("rst_rdata", s_axi_rdata, 32'd0);
        check("rst_ctrl_any", {31'd0, |ctrl_out}, 32'd0);
        check("rst_ctrl_wr", {24'd0, ctrl_wr}, 32'd0);
        rst = 1'b0;

        // Full-word write
        axi_write(32'h04, 32'h12345678, 4'hF, 0, resp, lat);
        check("w1_lat", lat, 1);
        check("w1_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        check("w1_word1", word(1), 32'h12345678);
        check("w1_pulse1", pulses[1], 1);
        check("w1_pulse0", pulses[0], 0);

        // Bridge-style byte write: W one cycle ahead of AW, late bready
        axi_write(32'h08, 32'h11223344, 4'hF, 0, resp, lat);
        check("pre_word2", word(2), 32'h11223344);
        @(negedge clk);
        s_axi_wdata = 32'hA5A5A5A5; s_axi_wstrb = 4'h8; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check("bw_wready_held", {31'd0, s_axi_wready}, 32'd0);
        s_axi_awaddr = 32'h08; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("bw_no_commit_yet", {31'd0, s_axi_bvalid}, 32'd0);
        wait_b(5, resp, lat);
        check("bw_lat", lat, 1);
        check("bw_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        check("bw_word2", word(2), 32'hA5223344);
        check("bw_pulse2", pulses[2], 2);
        $display("WRITE addr=00000008 data=a5a5a5a5 strb=8 bresp=%0d (W before AW)", resp);

        // Status read with late rready
        axi_read(32'h20, 3, rdata, resp, lat);
        check("st_lat", lat, 0);
        check("st_rdata", rdata, 32'hDEADBEEF);
        check("st_rresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        axi_read(32'h2C, 0, rdata, resp, lat);
        check("st3_rdata", rdata, 32'h0000C0DE);

        // Error paths and aliasing
        axi_write(32'h20, 32'hFFFFFFFF, 4'hF, 0, resp, lat);
        check("wstat_bresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
        axi_read(32'h20, 0, rdata, resp, lat);
        check("wstat_unchanged", rdata, 32'hDEADBEEF);
        axi_read(32'hFC, 0, rdata, resp, lat);
        check("unmap_rdata", rdata, 32'd0);
        check("unmap_rresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
        axi_write(32'h100, 32'hCAFEF00D, 4'hF, 0, resp, lat);
        check("alias_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        check("alias_word0", word(0), 32'hCAFEF00D);
        axi_read(32'h04, 0, rdata, resp, lat);
        check("rb_word1", rdata, 32'h12345678);

        // Zero strobe: commit without change, strobe still fires
        axi_write(32'h04, 32'h00000000, 4'h0, 0, resp, lat);
        check("z_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        check("z_word1", word(1), 32'h12345678);
        check("z_pulse1", pulses[1], 2);

        // Reset in the middle of a write
        axi_write(32'h0C, 32'h55AA55AA, 4'hF, 0, resp, lat);
        check("mw_pre_word3", word(3), 32'h55AA55AA);
        @(negedge clk);
        s_axi_awaddr = 32'h0C; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check("mw_aw_held", {31'd0, s_axi_awready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mw_ctrl_zero", {31'd0, |ctrl_out}, 32'd0);
        check("mw_ready", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
        repeat (3) @(negedge clk);
        check("mw_no_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        $display("RESET mid-write: ctrl_out_any=%0d bvalid=%0d", |ctrl_out, s_axi_bvalid);
        axi_write(32'h0C, 32'h0BADF00D, 4'hF, 0, resp, lat);
        check("mw_after_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        check("mw_after_word3", word(3), 32'h0BADF00D);

`ifdef RBCP_REG_BANK_WCNT_EN
        axi_write(32'h30, 32'h0, 4'hF, 0, resp, lat);
        check("cnt_clr_bresp", {30'd0, resp}, {30'd0, RESP_OKAY});
        axi_read(32'h30, 0, rdata, resp, lat);
        check("cnt_after_clr", rdata, 32'd0);
        axi_write(32'h00, 32'h1, 4'hF, 0, resp, lat);
        axi_write(32'h14, 32'h2, 4'hF, 0, resp, lat);
        axi_write(32'h1C, 32'h3, 4'h1, 0, resp, lat);
        axi_write(32'h24, 32'h4, 4'hF, 0, resp, lat);
        check("cnt_slverr_w", {30'd0, resp}, {30'd0, RESP_SLVERR});
        axi_read(32'h30, 0, rdata, resp, lat);
        check("cnt_value", rdata, 32'd3);
        check("cnt_rresp", {30'd0, resp}, {30'd0, RESP_OKAY});
`else
        axi_write(32'h30, 32'h0, 4'hF, 0, resp, lat);
        check("nocnt_bresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
        axi_read(32'h30, 0, rdata, resp, lat);
        check("nocnt_rdata", rdata, 32'd0);
        check("nocnt_rresp", {30'd0, resp}, {30'd0, RESP_SLVERR});
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rbcp_reg_bank.md
# rbcp_reg_bank

AXI4-Lite slave register bank that sits directly downstream of the RBCP-to-AXI bridge. It terminates the bridge's single-beat, byte-strobed AXI4-Lite transactions. It exposes N_CTRL read/write control words to the fabric and N_STAT read-only status words sampled from the fabric. Every transaction completes with a registered response, and unmapped accesses are reported with SLVERR.

## Interface
- N_CTRL, 8, number of 32-bit read/write control words (1..16)
- N_STAT, 4, number of 32-bit read-only status words (0..16)
- ADDR_W, 8, decoded byte-address bits; upper address bits are ignored (aliasing)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_axi_awaddr  in  32  write address; only [ADDR_W-1:2] used
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in / out  1  write-address handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables; bit n qualifies wdata[8n+7:8n]
- s_axi_wvalid / s_axi_wready  in / out  1  write-data handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  write-response handshake
- s_axi_araddr  in  32  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in / out  1  read-address handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out / in  1  read-data handshake
- ctrl_out  out  32*N_CTRL  control words; word k at [32k+31:32k]
- ctrl_wr  out  N_CTRL  one-cycle strobe per word, high in the cycle after that word is committed
- status_in  in  32*N_STAT  status words, sampled at read time

## Operation
- Word index is addr[ADDR_W-1:2]; addr[1:0] is ignored.
- Map: 0..N_CTRL-1 is control; N_CTRL..N_CTRL+N_STAT-1 is status; everything else is unmapped.
- Write path:
  - AW and W are accepted independently, in either order, into holding registers aw_held / w_held.
  - awready = ~aw_held & ~bvalid. wready = ~w_held & ~bvalid.
  - When both are held: commit on the next edge.
  - Control word: apply bytes per wstrb; bresp=OKAY; pulse ctrl_wr[k].
  - Status or unmapped word: no state change; bresp=SLVERR (2'b10).
  - On commit, both holds clear and bvalid rises. bvalid stays high until bready is sampled high.
- Read path:
  - arready = ~rvalid.
  - On AR handshake, the next edge registers rdata and rresp and sets rvalid.
  - Unmapped read returns rdata=0, rresp=SLVERR.
  - rvalid stays high, with rdata/rresp stable, until rready is sampled high.
- Read and write channels are fully independent. A read sampled on the same edge as a write commit to the same word returns the pre-write value.
- wstrb=0: commit proceeds, no bytes change, bresp=OKAY, ctrl_wr still pulses.

## Timing
- Reset values: awready=1, wready=1, arready=1, bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0, ctrl_out=0, ctrl_wr=0. Holds are cleared.
- Write, with AW and W handshaked at edge N:
  - Commit at N+1; ctrl_out and bvalid are visible after N+1.
  - ctrl_wr is high for the cycle between N+1 and N+2.
- Write, with AW at edge N and W at edge M>N: commit at M+1.
- Read: with AR handshaked at edge N, rvalid is visible after N. The minimum read turnaround is 2 cycles.
- While bvalid is high, no new AW or W is accepted.
- The bank tolerates a master that raises bready/rready one or more cycles late, or for a single cycle only.
- rst asserted mid-transaction aborts it: pending holds are discarded, bvalid and rvalid drop on the reset edge, and ctrl_out returns to 0.

## Configuration
- RBCP_REG_BANK_WCNT_EN defined:
  - Adds a 32-bit committed-write counter at word index N_CTRL+N_STAT.
  - It increments on every OKAY commit and wraps from 0xFFFFFFFF to 0.
  - A write to the counter word clears it to 0 with bresp=OKAY and is not itself counted.
  - Reads return the current count.
- Undefined: that index is unmapped (SLVERR), and no counter logic is present.

## Structure
- Package rbcp_reg_bank_pkg holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - Default N_CTRL/N_STAT/ADDR_W.
  - A byte-strobe merge function (old, new, strb).
- Sub-module rbcp_reg_bank_wcnt is the write counter, instantiated only under RBCP_REG_BANK_WCNT_EN. All other logic stays in the top module.

## Test plan
- Full-word write: AW+W together, addr 0x04, wdata 0x12345678, wstrb 0xF -> ctrl_out word1=0x12345678, bresp=OKAY, ctrl_wr[1] pulses once.
- Bridge-style byte write: W one cycle before AW, addr 0x08, wdata 0xA5A5A5A5, wstrb 0x8, word2 preloaded 0x11223344 -> word2=0xA5223344. Hold bready low 5 cycles -> bvalid held, awready=0 throughout.
- Status read: status_in word0=0xDEADBEEF, read addr N_CTRL*4=0x20 -> rdata=0xDEADBEEF, OKAY. Delay rready 3 cycles -> rdata stable.
- Error paths: write to 0x20 -> SLVERR, status unchanged. Read 0xFC -> rdata=0, SLVERR. Write 0x100 aliases word 0.
- Reset mid-write: AW accepted, rst before W -> no commit, bvalid=0, ctrl_out=0. A following full write completes normally.
- With RBCP_REG_BANK_WCNT_EN: 3 OKAY writes plus 1 SLVERR write, read 0x30 -> 3. Write 0x30 -> read 0x30 returns 0.
